pipeline_id_ex_stage: RTL and testbench



---
 rtl/pipeline_id_ex_stage_pkg.sv | 31 +++
 rtl/pipeline_id_ex_stage_if.sv | 38 +++
 rtl/pipeline_id_ex_stage_skid.sv | 82 ++++++++
 rtl/pipeline_id_ex_stage.sv | 50 +++++
 tb/tb_pipeline_id_ex_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_id_ex_stage_pkg.sv
// Shared types and constants for the ID->EX pipeline stage.
package pipeline_id_ex_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ALU_CTRL_W = 5;
  localparam int IDEX_XLEN  = 32;

  // Write-back source select carried in the control bundle.
  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC4 = 2'b10;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  alu_src;
    logic [1:0]            mem_to_reg;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [REG_ADDR_W-1:0] rd;
  } idex_ctrl_t;

  localparam int IDEX_CTRL_W = $bits(idex_ctrl_t);

  // Packed entry: pc, target, rd1, rd2, imm (XLEN each) plus control.
  function automatic int idex_payload_w(input int xlen);
    return 5 * xlen + IDEX_CTRL_W;
  endfunction

  localparam int IDEX_PAYLOAD_W = idex_payload_w(IDEX_XLEN);

endpackage

// File: rtl/pipeline_id_ex_stage_if.sv
// Decode-side and execute-side handshake bundle of the ID->EX stage.
interface pipeline_id_ex_stage_if
  import pipeline_id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rd1;
  logic [XLEN-1:0] id_rd2;
  logic [XLEN-1:0] id_imm;
  idex_ctrl_t      id_ctrl;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] ex_rd1;
  logic [XLEN-1:0] ex_rd2;
  logic [XLEN-1:0] ex_imm;
  idex_ctrl_t      ex_ctrl;

  // The stage itself.
  modport slave (
    input  flush, id_valid, id_pc, id_rd1, id_rd2, id_imm, id_ctrl, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_target, ex_rd1, ex_rd2, ex_imm, ex_ctrl
  );

  // Decode + execute neighbours driving the stage.
  modport master (
    output flush, id_valid, id_pc, id_rd1, id_rd2, id_imm, id_ctrl, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_target, ex_rd1, ex_rd2, ex_imm, ex_ctrl
  );

endinterface

// File: rtl/pipeline_id_ex_stage_skid.sv
// Generic 2-entry valid/ready skid buffer. in_ready is a flop, so there is
// no combinational path from out_ready back to the producer.
module pipeline_id_ex_stage_skid
  import pipeline_id_ex_stage_pkg::*;
#(
  parameter int W = IDEX_PAYLOAD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_reg, main_valid_next;
  logic [W-1:0] main_data_reg,  main_data_next;
  logic         skid_valid_reg, skid_valid_next;
  logic [W-1:0] skid_data_reg,  skid_data_next;
  logic         ready_reg,      ready_next;
  logic         accept, consume;

  assign accept  = in_valid & ready_reg;
  assign consume = main_valid_reg & out_ready;

  // Next-state: main always holds the oldest entry, skid the younger one.
  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg || consume) begin
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        skid_valid_next = accept;
        if (accept) skid_data_next = in_data;
      end else begin
        main_valid_next = accept;
        if (accept) main_data_next = in_data;
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
    end
    ready_next = !skid_valid_next;
  end

  // State update; ready stays low for the whole reset and rises one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      ready_reg      <= 1'b0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      ready_reg      <= ready_next;
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

  a_no_overrun: assert property (@(posedge clk) disable iff (!rst)
    accept |-> !skid_valid_reg);

endmodule

// File: rtl/pipeline_id_ex_stage.sv
// ID->EX pipeline stage: computes the branch target ahead of the skid buffer,
// packs the entry, and gates side-effecting control on bubbles.
module pipeline_id_ex_stage
  import pipeline_id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_id_ex_stage_if.slave bus
);

  localparam int W = idex_payload_w(XLEN);

  logic [XLEN-1:0] target;
  logic [W-1:0]    payload_in;
  logic [W-1:0]    payload_out;
  logic            out_valid;
  idex_ctrl_t      ctrl_raw;
  idex_ctrl_t      ctrl_gated;

  // Carry out of the add is intentionally dropped (mod 2^XLEN).
  assign target     = bus.id_pc + bus.id_imm;
  assign payload_in = {bus.id_pc, target, bus.id_rd1, bus.id_rd2, bus.id_imm, bus.id_ctrl};

  pipeline_id_ex_stage_skid #(.W(W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (bus.id_valid),
    .in_ready  (bus.id_ready),
    .in_data   (payload_in),
    .out_valid (out_valid),
    .out_ready (bus.ex_ready),
    .out_data  (payload_out)
  );

  assign {bus.ex_pc, bus.ex_target, bus.ex_rd1, bus.ex_rd2, bus.ex_imm, ctrl_raw} = payload_out;
  assign bus.ex_valid = out_valid;

  // A bubble must never write the register file or memory.
  always_comb begin
    ctrl_gated           = ctrl_raw;
    ctrl_gated.reg_write = ctrl_raw.reg_write & out_valid;
    ctrl_gated.mem_write = ctrl_raw.mem_write & out_valid;
  end

  assign bus.ex_ctrl = ctrl_gated;

endmodule

// File: tb/tb_pipeline_id_ex_stage.sv
// Bench for pipeline_id_ex_stage: directed cases plus a random run checked
// against a 2-deep FIFO model of the stage.
module tb_pipeline_id_ex_stage;
  import pipeline_id_ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_id_ex_stage_if #(.XLEN(32)) bus ();
  pipeline_id_ex_stage_if #(.XLEN(64)) bus64 ();

  pipeline_id_ex_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  pipeline_id_ex_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  typedef struct {
    logic [31:0] pc, target, rd1, rd2, imm;
    idex_ctrl_t  ctrl;
  } ent_t;

  ent_t q[$];      // entries held by the stage, oldest first
  bit   up = 1'b0; // an edge has passed since reset release
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic idex_ctrl_t rand_ctrl();
    idex_ctrl_t c;
    c = idex_ctrl_t'(IDEX_CTRL_W'($urandom));
    case ($urandom_range(0, 2))
      0:       c.mem_to_reg = MEM_TO_REG_ALU;
      1:       c.mem_to_reg = MEM_TO_REG_MEM;
      default: c.mem_to_reg = MEM_TO_REG_PC4;
    endcase
    return c;
  endfunction

  task automatic compare_outputs();
    check("id_ready", bus.id_ready, up && (q.size() < 2));
    check("ex_valid", bus.ex_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("ex_pc",     bus.ex_pc,     q[0].pc);
      check("ex_target", bus.ex_target, q[0].target);
      check("ex_rd1",    bus.ex_rd1,    q[0].rd1);
      check("ex_rd2",    bus.ex_rd2,    q[0].rd2);
      check("ex_imm",    bus.ex_imm,    q[0].imm);
      check("ex_ctrl",   bus.ex_ctrl,   q[0].ctrl);
    end else begin
      check("bubble_reg_write", bus.ex_ctrl.reg_write, 1'b0);
      check("bubble_mem_write", bus.ex_ctrl.mem_write, 1'b0);
    end
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge.
  task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] imm,
                       input bit rdy, input bit fl, input bit verbose);
    ent_t e;
    bit   acc, con;
    @(negedge clk);
    e.pc = pc; e.imm = imm; e.rd1 = $urandom; e.rd2 = $urandom; e.ctrl = rand_ctrl();
    e.target = pc + imm;
    bus.id_valid = v;  bus.id_pc = e.pc; bus.id_imm = e.imm;
    bus.id_rd1 = e.rd1; bus.id_rd2 = e.rd2; bus.id_ctrl = e.ctrl;
    bus.ex_ready = rdy; bus.flush = fl;
    #1 compare_outputs();
    @(posedge clk);
    if (rst) begin
      acc = v && up && (q.size() < 2);
      con = rdy && (q.size() > 0);
      if (fl) q.delete();
      else begin
        if (con) begin
          if (verbose) $display("txn pc=%08h target=%08h rd=%0d", q[0].pc, q[0].target, q[0].ctrl.rd);
          void'(q.pop_front());
        end
        if (acc) q.push_back(e);
      end
      up = 1'b1;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    bus.id_valid = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b0;
    rst = 1'b1;
    #1 check("ready_before_edge", bus.id_ready, 1'b0);
    @(posedge clk);
    up = 1'b1;
    #1 check("ready_after_edge", bus.id_ready, 1'b1);
  endtask

  task automatic cycle64(input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] exp_t);
    @(negedge clk);
    bus64.id_valid = 1'b1; bus64.id_pc = pc; bus64.id_imm = imm; bus64.ex_ready = 1'b1;
    @(posedge clk);
    #1;
    check("x64_valid",  bus64.ex_valid,  1'b1);
    check("x64_pc",     bus64.ex_pc,     pc);
    check("x64_target", bus64.ex_target, exp_t);
  endtask

  initial begin
    bus.flush = 0; bus.id_valid = 0; bus.ex_ready = 0;
    bus.id_pc = 0; bus.id_rd1 = 0; bus.id_rd2 = 0; bus.id_imm = 0; bus.id_ctrl = '0;
    bus64.flush = 0; bus64.id_valid = 0; bus64.ex_ready = 0;
    bus64.id_pc = 0; bus64.id_rd1 = 0; bus64.id_rd2 = 0; bus64.id_imm = 0; bus64.id_ctrl = '0;
    #1;
    check("rst_ex_valid", bus.ex_valid, 1'b0);
    check("rst_id_ready", bus.id_ready, 1'b0);
    repeat (2) @(posedge clk);
    release_reset();

    // Stream at full rate.
    cycle(1, 32'h100, 32'h10, 1, 0, 1); #1 check("stream_t0", bus.ex_target, 32'h110);
    cycle(1, 32'h104, 32'h10, 1, 0, 1); #1 check("stream_t1", bus.ex_target, 32'h114);
    cycle(1, 32'h108, 32'h10, 1, 0, 1); #1 check("stream_t2", bus.ex_target, 32'h118);
    cycle(0, 0, 0, 1, 0, 1);

    // Backpressure: A held on outputs, B parked in skid.
    cycle(1, 32'h200, 32'h4, 0, 0, 1);
    cycle(1, 32'h300, 32'h8, 0, 0, 1);
    #1 check("bp_hold_pc", bus.ex_pc, 32'h200); check("bp_ready", bus.id_ready, 1'b0);
    cycle(1, 32'h999, 32'h0, 0, 0, 1);
    #1 check("bp_still_a", bus.ex_pc, 32'h200);
    cycle(0, 0, 0, 1, 0, 1);
    #1 check("bp_then_b", bus.ex_pc, 32'h300); check("bp_ready_back", bus.id_ready, 1'b1);
    cycle(0, 0, 0, 1, 0, 1);
    #1 check("bp_drained", bus.ex_valid, 1'b0);

    // Flush with both entries full and a valid input.
    cycle(1, 32'h400, 0, 0, 0, 1);
    cycle(1, 32'h500, 0, 0, 0, 1);
    cycle(1, 32'h600, 0, 0, 1, 1);
    #1 check("fl_valid", bus.ex_valid, 1'b0); check("fl_ready", bus.id_ready, 1'b1);
    check("fl_rw", bus.ex_ctrl.reg_write, 1'b0); check("fl_mw", bus.ex_ctrl.mem_write, 1'b0);
    // Flush with a same-cycle accept: the accept is dropped.
    cycle(1, 32'h700, 0, 0, 0, 1);
    cycle(1, 32'h800, 0, 1, 1, 1);
    #1 check("fl_drop_accept", bus.ex_valid, 1'b0);
    repeat (2) cycle(0, 0, 0, 1, 0, 1);

    // Target wrap-around.
    cycle(1, 32'hFFFF_FFF0, 32'h20, 1, 0, 1);       #1 check("wrap_t0", bus.ex_target, 32'h0000_0010);
    cycle(1, 32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 1); #1 check("wrap_t1", bus.ex_target, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1, 0, 1);

    // Reset mid-stream with both entries full.
    cycle(1, 32'hA00, 32'h1, 0, 0, 1);
    cycle(1, 32'hB00, 32'h1, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0; q.delete(); up = 1'b0;
    #1;
    check("mid_rst_valid", bus.ex_valid, 1'b0);
    check("mid_rst_ready", bus.id_ready, 1'b0);
    check("mid_rst_pc", bus.ex_pc, 32'h0);
    check("mid_rst_target", bus.ex_target, 32'h0);
    check("mid_rst_rd1", bus.ex_rd1, 32'h0);
    cycle(1, 32'hC00, 32'h1, 1, 0, 1);
    release_reset();

    // Random traffic.
    for (int i = 0; i < 10000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, 0);
    repeat (3) cycle(0, 0, 0, 1, 0, 0);

    // 64-bit datapath: no 32-bit wrap, wraps at 2^64.
    cycle64(64'h100, 64'h10, 64'h110);
    cycle64(64'h104, 64'h10, 64'h114);
    cycle64(64'h108, 64'h10, 64'h118);
    cycle64(64'hFFFF_FFF0, 64'h20, 64'h1_0000_0010);
    cycle64(64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h10);
    @(negedge clk);
    bus64.id_valid = 1'b0;
    @(posedge clk);
    #1 check("x64_drained", bus64.ex_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
